// File: rtl/ctrl_pkg.sv
// Shared types, opcode constants and decode helpers for the multi-cycle sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LD  = 3'd2,
        CLS_SD  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_ILL = 3'd5
    } cls_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    // Map a raw opcode onto its instruction class; anything unknown is illegal.
    function automatic cls_t decode_class(input logic [6:0] op);
        case (op)
            OP_R:    return CLS_R;
            OP_I:    return CLS_I;
            OP_LD:   return CLS_LD;
            OP_SD:   return CLS_SD;
            OP_BEQ:  return CLS_BEQ;
            default: return CLS_ILL;
        endcase
    endfunction

    // ALU operation code driven while a class is in EXEC/MEM/WB.
    function automatic logic [1:0] alu_op_for(input cls_t c);
        case (c)
            CLS_R:   return ALU_OP_RTYPE;
            CLS_I:   return ALU_OP_ITYPE;
            CLS_BEQ: return ALU_OP_SUB;
            default: return ALU_OP_ADD;
        endcase
    endfunction

    // Second ALU operand: register for R/BEQ, immediate for everything else.
    function automatic logic alu_src_for(input cls_t c);
        return !(c == CLS_R || c == CLS_BEQ);
    endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Memory-wait watchdog: counts stalled cycles and flags the one that would reach the limit.
module ctrl_timeout_cnt
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    // Count stalled cycles; cleared whenever the sequencer changes state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // The stalled cycle that would bring the count to MEM_TIMEOUT is the expiring one.
    assign expired_o = en_i && (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout and sticky trap.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    output logic             imem_req_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t           state_q, state_d;
    cls_t             cls_q;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             tmo_en;
    logic             tmo_clr;
    logic             tmo_expired;

    ctrl_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    // Any state change (entry to FETCH/MEM included) restarts the wait count.
    assign tmo_clr = (state_d != state_q);

    // State, class, trap cause and retire counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_R;
            cause_q   <= TRAP_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == ST_DECODE) begin
                cls_q <= decode_class(opcode_i);
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode; reset forces every output low.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        tmo_en       = 1'b0;
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = ALU_OP_ADD;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        trap_o       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                tmo_en = !imem_ready_i;
                if (imem_ready_i) begin
                    imem_req_o = 1'b1;
                    ir_we_o    = 1'b1;
                    pc_we_o    = 1'b1;
                    state_d    = ST_DECODE;
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_IMEM;
                end else begin
                    imem_req_o = 1'b1;
                end
            end
            ST_DECODE: begin
                if (decode_class(opcode_i) == CLS_ILL) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_o = alu_src_for(cls_q);
                alu_op_o  = alu_op_for(cls_q);
                case (cls_q)
                    CLS_BEQ: begin
                        pc_we_o  = zero_i;
                        pc_src_o = zero_i;
                        state_d  = ST_FETCH;
                        retire   = 1'b1;
                    end
                    CLS_R, CLS_I:   state_d = ST_WB;
                    CLS_LD, CLS_SD: state_d = ST_MEM;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                alu_src_o = alu_src_for(cls_q);
                alu_op_o  = alu_op_for(cls_q);
                tmo_en    = !dmem_ready_i;
                if (dmem_ready_i || !tmo_expired) begin
                    mem_read_o  = (cls_q == CLS_LD);
                    mem_write_o = (cls_q == CLS_SD);
                end
                if (dmem_ready_i) begin
                    if (cls_q == CLS_LD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_DMEM;
                end
            end
            ST_WB: begin
                alu_src_o    = alu_src_for(cls_q);
                alu_op_o     = alu_op_for(cls_q);
                reg_write_o  = 1'b1;
                mem_to_reg_o = (cls_q == CLS_LD);
                state_d      = ST_FETCH;
                retire       = 1'b1;
            end
            ST_TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst_i) begin
            imem_req_o   = 1'b0;
            ir_we_o      = 1'b0;
            pc_we_o      = 1'b0;
            pc_src_o     = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_o    = 1'b0;
            alu_op_o     = ALU_OP_ADD;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            mem_to_reg_o = 1'b0;
            trap_o       = 1'b0;
        end
    end

    assign trap_cause_o = cause_q;
    assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MEM_TIMEOUT=16, CNT_W=4).
module tb_multicycle_ctrl;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] SD_OP  = 7'b0100011;
    localparam logic [6:0] BEQ_OP = 7'b1100011;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req, ir_we, pc_we, pc_src, reg_write, alu_src;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, mem_to_reg, trap;
    logic [1:0] trap_cause;
    logic [3:0] instret;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(
        .MEM_TIMEOUT (16),
        .CNT_W       (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .imem_ready_i (imem_ready),
        .dmem_ready_i (dmem_ready),
        .imem_req_o   (imem_req),
        .ir_we_o      (ir_we),
        .pc_we_o      (pc_we),
        .pc_src_o     (pc_src),
        .reg_write_o  (reg_write),
        .alu_src_o    (alu_src),
        .alu_op_o     (alu_op),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_to_reg_o (mem_to_reg),
        .trap_o       (trap),
        .trap_cause_o (trap_cause),
        .instret_o    (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        opcode     = 7'd0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        tick();
        // Reset: everything low
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_ir_we", 32'(ir_we), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);

        rst        = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("rel_imem_req", 32'(imem_req), 32'd1);
        chk("rel_ir_we", 32'(ir_we), 32'd1);
        chk("rel_pc_we", 32'(pc_we), 32'd1);
        chk("rel_pc_src", 32'(pc_src), 32'd0);

        // R-type
        opcode = R_OP;
        tick();
        chk("r_dec_ir_we", 32'(ir_we), 32'd0);
        chk("r_dec_imem_req", 32'(imem_req), 32'd0);
        tick();
        chk("r_exec_alu_op", 32'(alu_op), 32'd2);
        chk("r_exec_alu_src", 32'(alu_src), 32'd0);
        chk("r_exec_reg_write", 32'(reg_write), 32'd0);
        tick();
        chk("r_wb_reg_write", 32'(reg_write), 32'd1);
        chk("r_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
        chk("r_wb_alu_op", 32'(alu_op), 32'd2);
        chk("r_wb_instret", 32'(instret), 32'd0);
        tick();
        chk("r_done_imem_req", 32'(imem_req), 32'd1);
        chk("r_done_instret", 32'(instret), 32'd1);

        // LD with three stalled memory cycles
        opcode     = LD_OP;
        dmem_ready = 1'b0;
        tick();
        tick();
        chk("ld_exec_alu_src", 32'(alu_src), 32'd1);
        chk("ld_exec_alu_op", 32'(alu_op), 32'd0);
        chk("ld_exec_mem_read", 32'(mem_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_mem_wait_read", 32'(mem_read), 32'd1);
        end
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("ld_mem_ready_read", 32'(mem_read), 32'd1);
        tick();
        chk("ld_wb_mem_read", 32'(mem_read), 32'd0);
        chk("ld_wb_reg_write", 32'(reg_write), 32'd1);
        chk("ld_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("ld_wb_instret", 32'(instret), 32'd1);
        tick();
        chk("ld_done_imem_req", 32'(imem_req), 32'd1);
        chk("ld_done_instret", 32'(instret), 32'd2);

        // BEQ taken
        opcode = BEQ_OP;
        zero   = 1'b1;
        tick();
        tick();
        chk("beq_t_pc_we", 32'(pc_we), 32'd1);
        chk("beq_t_pc_src", 32'(pc_src), 32'd1);
        chk("beq_t_alu_op", 32'(alu_op), 32'd1);
        tick();
        chk("beq_t_fetch", 32'(imem_req), 32'd1);
        chk("beq_t_instret", 32'(instret), 32'd3);

        // BEQ not taken
        zero = 1'b0;
        tick();
        tick();
        chk("beq_nt_pc_we", 32'(pc_we), 32'd0);
        chk("beq_nt_alu_op", 32'(alu_op), 32'd1);
        tick();
        chk("beq_nt_fetch", 32'(imem_req), 32'd1);
        chk("beq_nt_instret", 32'(instret), 32'd4);

        // SD with immediate ready
        opcode = SD_OP;
        tick();
        tick();
        tick();
        chk("sd_mem_write", 32'(mem_write), 32'd1);
        chk("sd_mem_read", 32'(mem_read), 32'd0);
        chk("sd_alu_src", 32'(alu_src), 32'd1);
        tick();
        chk("sd_done_fetch", 32'(imem_req), 32'd1);
        chk("sd_done_write", 32'(mem_write), 32'd0);
        chk("sd_done_instret", 32'(instret), 32'd5);

        // I-type run to wrap the 4-bit counter (5 + 11 = 16 -> 0)
        opcode = I_OP;
        for (int i = 0; i < 11; i++) begin
            tick();
            tick();
            tick();
            if (i == 0) begin
                chk("i_wb_alu_op", 32'(alu_op), 32'd3);
                chk("i_wb_alu_src", 32'(alu_src), 32'd1);
            end
            tick();
            chk("wrap_instret", 32'(instret), 32'((6 + i) % 16));
        end
        chk("wrap_zero", 32'(instret), 32'd0);

        // Reset in the middle of a stalled SD
        opcode     = SD_OP;
        dmem_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_mem_write", 32'(mem_write), 32'd1);
        tick();
        chk("mid_mem_write2", 32'(mem_write), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_mem_write", 32'(mem_write), 32'd0);
        rst        = 1'b0;
        imem_ready = 1'b0;
        #1;
        chk("mid_rst_fetch", 32'(imem_req), 32'd1);
        chk("mid_rst_mem_write_after", 32'(mem_write), 32'd0);

        // Instruction fetch timeout: 16 stalled cycles in FETCH
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("tmo_16th_req", 32'(imem_req), 32'd0);
        chk("tmo_16th_ir_we", 32'(ir_we), 32'd0);
        chk("tmo_16th_trap", 32'(trap), 32'd0);
        tick();
        chk("tmo_trap", 32'(trap), 32'd1);
        chk("tmo_cause", 32'(trap_cause), 32'd2);
        imem_ready = 1'b1;
        #1;
        chk("tmo_hold_req", 32'(imem_req), 32'd0);
        tick();
        tick();
        chk("tmo_sticky", 32'(trap), 32'd1);
        chk("tmo_instret", 32'(instret), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("tmo_clear_trap", 32'(trap), 32'd0);
        chk("tmo_clear_cause", 32'(trap_cause), 32'd0);

        // Ready arrives on the last allowed cycle: no trap
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        imem_ready = 1'b1;
        #1;
        chk("edge_ir_we", 32'(ir_we), 32'd1);
        opcode = R_OP;
        tick();
        chk("edge_no_trap", 32'(trap), 32'd0);
        tick();
        tick();
        tick();
        chk("edge_instret", 32'(instret), 32'd1);

        // Illegal opcode
        opcode = BAD_OP;
        tick();
        tick();
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        tick();
        tick();
        tick();
        chk("ill_sticky", 32'(trap), 32'd1);
        chk("ill_ir_we", 32'(ir_we), 32'd0);
        chk("ill_imem_req", 32'(imem_req), 32'd0);
        chk("ill_instret", 32'(instret), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ill_clear_trap", 32'(trap), 32'd0);
        chk("ill_clear_cause", 32'(trap_cause), 32'd0);
        chk("ill_clear_instret", 32'(instret), 32'd0);
        chk("ill_clear_fetch", 32'(imem_req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
